hunter_ook_rx: RTL and testbench
================================

Name: hunter_ook_rx

Overview:
- OOK demodulated-data frame decoder. It is the receive counterpart to the 350 MHz carrier transmit path.
- Takes the digital data output of an external 350 MHz superhet receiver module. Synchronises and deglitches it, measures pulse widths, classifies PWM bits, and assembles fixed-length Hunter remote frames.
- Delivers each frame over a valid/ready interface to the command logic.
- Runs in the 12 MHz reference clock domain.

Parameters:
- FRAME_BITS, 24, data bits per frame.
- SHORT_MIN, 3600, minimum high width in cycles for a 0 bit (300 us at 12 MHz).
- SHORT_MAX, 6000, maximum high width for a 0 bit.
- LONG_MIN, 8400, minimum high width for a 1 bit.
- LONG_MAX, 10800, maximum high width for a 1 bit.
- SYNC_MIN, 60000, minimum low gap in cycles that arms frame start (5 ms).
- GLITCH, 24, number of consecutive cycles a new level must hold before it is accepted (2 us).

Ports:
- ref_12mhz  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- rx_data  input  1  asynchronous demodulated OOK data from the receiver module.
- frame_data  output  FRAME_BITS  received frame, first-received bit in MSB.
- frame_valid  output  1  frame_data holds an unconsumed frame.
- frame_ready  input  1  consumer accepts the frame.
- frame_err  output  1  one-cycle pulse on frame abort.
- overrun  output  1  sticky; set when a completed frame is dropped because the buffer is full.

Behaviour:
- Reset (synchronous on rising ref_12mhz with rst=1):
  - frame_data=0, frame_valid=0, frame_err=0, overrun=0.
  - State IDLE, synchroniser and filter cleared to 0, counters 0.
  - Reset mid-frame discards all partial state.
- Input conditioning:
  - 2-FF synchroniser feeds a glitch filter.
  - The filtered level lv changes only after the synchronised input differs from lv for GLITCH consecutive cycles.
  - Total latency from rx_data to lv is 2+GLITCH cycles.
- Width counter:
  - 16 bits, cleared on every lv edge.
  - Saturates at 0xFFFF; it never wraps.
- FSM states:
  - IDLE: wait for lv=0; go to GAP.
  - GAP:
    - count low time.
    - lv rising with count >= SYNC_MIN → HIGH, bit count cleared.
    - lv rising with count < SYNC_MIN → IDLE.
  - HIGH: on lv falling, classify the high width.
    - Width in [SHORT_MIN,SHORT_MAX] → shift in 0.
    - Width in [LONG_MIN,LONG_MAX] → shift in 1.
    - Any other width → ERR.
    - If bit count reaches FRAME_BITS after the shift → DONE; otherwise → LOW.
    - A high longer than LONG_MAX while still high → ERR immediately.
  - LOW:
    - lv rising → HIGH.
    - Low width exceeding LONG_MAX → ERR (truncated frame).
  - DONE (one cycle):
    - frame_valid=0, or frame_valid=1 with frame_ready=1 in this same cycle: load frame_data, frame_valid=1 next cycle.
    - Otherwise set overrun and drop the new frame.
    - Then go to GAP.
  - ERR (one cycle): pulse frame_err, then go to GAP. The low time counted in GAP after ERR restarts at the first lv falling edge.
- Handshake:
  - frame_valid clears the cycle after frame_valid && frame_ready.
  - frame_data stays stable while frame_valid=1.
  - Simultaneous accept plus new DONE: the new frame is loaded, frame_valid stays 1, no overrun.
- overrun clears only on rst.

Optional Feature:
- Macro: HUNTER_OOK_RX_REPEAT_FILTER_EN.
- Defined:
  - Remotes repeat each frame several times; a frame is delivered only when it equals the immediately preceding completed frame.
  - The match must follow with no ERR in between.
  - After a delivery, further identical repeats are suppressed until a different frame, an ERR, or a GAP lasting longer than 4*SYNC_MIN occurs.
- Undefined: every completed frame is delivered.

Decomposition:
- Package hunter_ook_pkg holds:
  - FSM state enum: IDLE, GAP, HIGH, LOW, DONE, ERR.
  - Default timing constants, expressed in 12 MHz cycles.
  - Counter width constant (16).
- One sub-module, hunter_ook_deglitch: 2-FF synchroniser plus glitch filter, parameterised by GLITCH.

Test Plan:
- Valid frame:
  - Stimulus: 6 ms low, then 24 bits of pattern 0xA5C3F0; 0 = 400 us high/800 us low, 1 = 800 us high/400 us low.
  - Required: frame_valid rises with frame_data=0xA5C3F0, frame_err=0.
- Glitch rejection:
  - Stimulus: 1 us spikes inserted in the lows and highs of the valid frame.
  - Required: same 0xA5C3F0, no frame_err.
- Bad width:
  - Stimulus: bit 10 high width of 600 us.
  - Required: frame_err pulses once; no frame_valid.
  - Stimulus: next clean frame 0x000001 after a 6 ms gap.
  - Required: frame 0x000001 delivered.
- Backpressure:
  - Stimulus: frame_ready=0, two frames 0x111111 then 0x222222.
  - Required: frame_data stays 0x111111, overrun=1.
  - Stimulus: then frame_ready=1.
  - Required: frame_valid drops next cycle.
- Reset mid-frame:
  - Stimulus: rst asserted after bit 12.
  - Required: all outputs 0.
  - Stimulus: next full frame.
  - Required: decoded correctly.
- Repeat filter (macro defined):
  - Stimulus: three identical 0x0F0F0F frames.
  - Required: exactly one frame_valid, after the second frame.
  - Stimulus: 0x0F0F0E, then 0x0F0F0F.
  - Required: no delivery.

Source files
------------

// File: rtl/hunter_ook_pkg.sv
// Shared types and default timing for the Hunter OOK frame receiver.
// Timing constants are in 12 MHz reference clock cycles.
package hunter_ook_pkg;

  localparam int CNT_W = 16;

  localparam int DEF_FRAME_BITS = 24;
  localparam int DEF_SHORT_MIN  = 3600;
  localparam int DEF_SHORT_MAX  = 6000;
  localparam int DEF_LONG_MIN   = 8400;
  localparam int DEF_LONG_MAX   = 10800;
  localparam int DEF_SYNC_MIN   = 60000;
  localparam int DEF_GLITCH     = 24;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    HIGH,
    LOW,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/hunter_ook_rx_deglitch.sv
// Two-flop synchroniser followed by a level filter: the output follows the
// synchronised input only after it has differed for GLITCH consecutive cycles.
module hunter_ook_deglitch #(
  parameter int GLITCH = 24
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level
);

  localparam int GW = (GLITCH < 2) ? 1 : $clog2(GLITCH + 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic [GW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      // Any return to the current level restarts the qualification window.
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == GW'(GLITCH - 1)) begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/hunter_ook_rx.sv
// Hunter remote OOK frame decoder: deglitch, pulse-width classify, assemble, hand off.
// Optional build macro HUNTER_OOK_RX_REPEAT_FILTER_EN delivers only repeated frames.
module hunter_ook_rx
  import hunter_ook_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int SHORT_MIN  = DEF_SHORT_MIN,
  parameter int SHORT_MAX  = DEF_SHORT_MAX,
  parameter int LONG_MIN   = DEF_LONG_MIN,
  parameter int LONG_MAX   = DEF_LONG_MAX,
  parameter int SYNC_MIN   = DEF_SYNC_MIN,
  parameter int GLITCH     = DEF_GLITCH
) (
  input  logic                  ref_12mhz,
  input  logic                  rst,
  input  logic                  rx_data,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W:0] P_SHORT_MIN = (CNT_W + 1)'(SHORT_MIN);
  localparam logic [CNT_W:0] P_SHORT_MAX = (CNT_W + 1)'(SHORT_MAX);
  localparam logic [CNT_W:0] P_LONG_MIN  = (CNT_W + 1)'(LONG_MIN);
  localparam logic [CNT_W:0] P_LONG_MAX  = (CNT_W + 1)'(LONG_MAX);
  localparam logic [CNT_W:0] P_SYNC_MIN  = (CNT_W + 1)'(SYNC_MIN);

  logic                  w_lv;
  logic                  w_rise;
  logic                  w_fall;
  logic [CNT_W:0]        w_width;
  logic                  w_is_zero;
  logic                  w_is_one;
  logic                  w_deliver;

  logic                  r_lv_d;
  logic [CNT_W-1:0]      r_cnt;
  state_t                r_state;
  logic [BW-1:0]         r_bits;
  logic [FRAME_BITS-1:0] r_shift;

  hunter_ook_deglitch #(
    .GLITCH (GLITCH)
  ) u_deglitch (
    .i_clk   (ref_12mhz),
    .i_rst   (rst),
    .i_async (rx_data),
    .o_level (w_lv)
  );

  assign w_rise    = w_lv & ~r_lv_d;
  assign w_fall    = ~w_lv & r_lv_d;
  // Counter is cleared on the edge cycle, so +1 gives the full level duration.
  assign w_width   = {1'b0, r_cnt} + 1'b1;
  assign w_is_zero = (w_width >= P_SHORT_MIN) && (w_width <= P_SHORT_MAX);
  assign w_is_one  = (w_width >= P_LONG_MIN) && (w_width <= P_LONG_MAX);

  always_ff @(posedge ref_12mhz) begin
    if (rst) begin
      r_lv_d <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_lv_d <= w_lv;
      if (w_rise || w_fall) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ref_12mhz) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bits      <= '0;
      r_shift     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err <= (r_state == ERR);
      if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (!w_lv) r_state <= GAP;
        end
        GAP: begin
          if (w_rise) begin
            if (w_width >= P_SYNC_MIN) begin
              r_state <= HIGH;
              r_bits  <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        HIGH: begin
          if (w_fall) begin
            if (w_is_zero || w_is_one) begin
              r_shift <= {r_shift[FRAME_BITS-2:0], w_is_one};
              r_bits  <= r_bits + 1'b1;
              r_state <= (r_bits == BW'(FRAME_BITS - 1)) ? DONE : LOW;
            end else begin
              r_state <= ERR;
            end
          end else if (w_width > P_LONG_MAX) begin
            r_state <= ERR;
          end
        end
        LOW: begin
          if (w_rise) begin
            r_state <= HIGH;
          end else if (w_width > P_LONG_MAX) begin
            r_state <= ERR;
          end
        end
        DONE: begin
          if (w_deliver) begin
            if (!frame_valid || frame_ready) begin
              frame_data  <= r_shift;
              frame_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
          r_state <= GAP;
        end
        ERR: begin
          r_state <= GAP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef HUNTER_OOK_RX_REPEAT_FILTER_EN
  localparam int LG_LIMIT = 4 * SYNC_MIN;
  localparam int LG_W     = $clog2(LG_LIMIT + 2);

  logic [FRAME_BITS-1:0] r_prev;
  logic                  r_prev_ok;
  logic                  r_suppress;
  logic [LG_W-1:0]       r_long;
  logic                  w_match;

  assign w_match   = r_prev_ok && (r_shift == r_prev);
  assign w_deliver = w_match && !r_suppress;

  always_ff @(posedge ref_12mhz) begin
    if (rst) begin
      r_prev     <= '0;
      r_prev_ok  <= 1'b0;
      r_suppress <= 1'b0;
      r_long     <= '0;
    end else begin
      // Separate wide counter: the 16-bit width counter cannot reach 4*SYNC_MIN.
      if (r_state == GAP && !w_lv) begin
        if (r_long <= LG_W'(LG_LIMIT)) r_long <= r_long + 1'b1;
      end else begin
        r_long <= '0;
      end
      if (r_state == DONE) begin
        r_prev     <= r_shift;
        r_prev_ok  <= 1'b1;
        r_suppress <= w_match;
      end else if (r_state == ERR) begin
        r_prev_ok  <= 1'b0;
        r_suppress <= 1'b0;
      end else if (r_long > LG_W'(LG_LIMIT)) begin
        r_suppress <= 1'b0;
      end
    end
  end
`else
  assign w_deliver = 1'b1;
`endif

endmodule

// File: tb/tb_hunter_ook_rx.sv
// Directed/randomised bench for hunter_ook_rx with timing scaled down 200x.
`timescale 1ns/1ps
module tb_hunter_ook_rx;

  localparam int FB   = 24;
  localparam int SMIN = 18;
  localparam int SMAX = 30;
  localparam int LMIN = 42;
  localparam int LMAX = 54;
  localparam int SYNC = 300;
  localparam int GL   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b0;
  logic          ready = 1'b1;
  logic [FB-1:0] fdata;
  logic          fvalid;
  logic          ferr;
  logic          ovr;

  int total = 0;
  int bad = 0;
  int n_load = 0;
  int n_err = 0;
  logic [FB-1:0] last_data = '0;
  logic          p_valid = 1'b0;
  logic          p_ready = 1'b0;
  logic [FB-1:0] p_data = '0;

  always #5 clk = ~clk;

  hunter_ook_rx #(
    .FRAME_BITS (FB),
    .SHORT_MIN  (SMIN),
    .SHORT_MAX  (SMAX),
    .LONG_MIN   (LMIN),
    .LONG_MAX   (LMAX),
    .SYNC_MIN   (SYNC),
    .GLITCH     (GL)
  ) dut (
    .ref_12mhz   (clk),
    .rst         (rst),
    .rx_data     (rx),
    .frame_data  (fdata),
    .frame_valid (fvalid),
    .frame_ready (ready),
    .frame_err   (ferr),
    .overrun     (ovr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observer: counts delivered frames and error pulses, checks data holds under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      p_valid = 1'b0;
      p_ready = 1'b0;
    end else begin
      if (p_valid && !p_ready && fvalid) check("hold_data", fdata, p_data);
      if (fvalid && !(p_valid && !p_ready)) begin
        n_load++;
        last_data = fdata;
        $display("frame delivered: %06h", fdata);
      end
      if (ferr) begin
        n_err++;
        $display("frame_err pulse");
      end
      p_valid = fvalid;
      p_ready = ready;
      p_data  = fdata;
    end
  end

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic drive(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends a frame and predicts its outcome from the high-width classification rules.
  task automatic send_frame(input logic [FB-1:0] d, input int nbits, input int bad_bit,
                            input int bad_w, input bit spikes, input bit fixed,
                            output bit ok, output logic [FB-1:0] expv);
    int h;
    int l;
    bit b;
    ok   = 1'b1;
    expv = '0;
    drive(1'b0, SYNC + 60);
    for (int i = 0; i < nbits; i++) begin
      b = d[FB-1-i];
      if (fixed) begin
        h = b ? 48 : 24;
        l = b ? 24 : 48;
      end else begin
        h = b ? rnd(LMIN + 2, LMAX - 2) : rnd(SMIN + 2, SMAX - 2);
        l = rnd(SMIN, 48);
      end
      if (i == bad_bit) h = bad_w;
      if (h >= SMIN && h <= SMAX) expv = {expv[FB-2:0], 1'b0};
      else if (h >= LMIN && h <= LMAX) expv = {expv[FB-2:0], 1'b1};
      else ok = 1'b0;
      if (spikes) begin
        drive(1'b1, h / 2); drive(1'b0, 1); drive(1'b1, h - h / 2 - 1);
      end else begin
        drive(1'b1, h);
      end
      if (i < nbits - 1) begin
        if (spikes) begin
          drive(1'b0, l / 2); drive(1'b1, 1); drive(1'b0, l - l / 2 - 1);
        end else begin
          drive(1'b0, l);
        end
      end
    end
    drive(1'b0, 20);
  endtask

  task automatic expect_frame(input string tag, input int l0, input int e0, input int exp_load,
                              input int exp_err, input logic [FB-1:0] expv);
    check({tag, "_load"}, 32'(n_load - l0), 32'(exp_load));
    check({tag, "_err"}, 32'(n_err - e0), 32'(exp_err));
    if (exp_load != 0) check({tag, "_data"}, 32'(last_data), 32'(expv));
  endtask

  initial begin
    bit            ok;
    logic [FB-1:0] ev;
    logic [FB-1:0] d;
    int            l0;
    int            e0;
    logic [FB-1:0] m_prev;
    bit            m_has;
    bit            m_sup;
    bit            match;
    logic [FB-1:0] rep [5];

    m_prev = '0;
    m_has  = 1'b0;
    m_sup  = 1'b0;
    rep[0] = 24'h0F0F0F; rep[1] = 24'h0F0F0F; rep[2] = 24'h0F0F0F;
    rep[3] = 24'h0F0F0E; rep[4] = 24'h0F0F0F;

    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(fdata), 32'h0);
    check("rst_valid", 32'(fvalid), 32'h0);
    check("rst_err", 32'(ferr), 32'h0);
    check("rst_ovr", 32'(ovr), 32'h0);
    rst = 1'b0;

`ifdef HUNTER_OOK_RX_REPEAT_FILTER_EN
    for (int k = 0; k < 5; k++) begin
      l0 = n_load; e0 = n_err;
      send_frame(rep[k], FB, -1, 0, 1'b0, 1'b0, ok, ev);
      match = m_has && (ev == m_prev);
      expect_frame($sformatf("repeat%0d", k), l0, e0, (ok && match && !m_sup) ? 1 : 0, ok ? 0 : 1, ev);
      m_sup  = match;
      m_prev = ev;
      m_has  = ok;
    end
`else
    l0 = n_load; e0 = n_err;
    send_frame(24'hA5C3F0, FB, -1, 0, 1'b0, 1'b1, ok, ev);
    expect_frame("valid", l0, e0, ok ? 1 : 0, ok ? 0 : 1, ev);

    l0 = n_load; e0 = n_err;
    send_frame(24'hA5C3F0, FB, -1, 0, 1'b1, 1'b1, ok, ev);
    expect_frame("glitch", l0, e0, ok ? 1 : 0, ok ? 0 : 1, ev);

    l0 = n_load; e0 = n_err;
    send_frame(24'hA5C3F0, FB, 10, 36, 1'b0, 1'b1, ok, ev);
    expect_frame("badw", l0, e0, ok ? 1 : 0, ok ? 0 : 1, ev);

    l0 = n_load; e0 = n_err;
    send_frame(24'h000001, FB, -1, 0, 1'b0, 1'b1, ok, ev);
    expect_frame("after_err", l0, e0, ok ? 1 : 0, ok ? 0 : 1, ev);

    for (int k = 0; k < 4; k++) begin
      d = FB'($urandom);
      l0 = n_load; e0 = n_err;
      send_frame(d, FB, (k == 2) ? rnd(0, FB - 1) : -1, 70, k[0], 1'b0, ok, ev);
      expect_frame($sformatf("rand%0d", k), l0, e0, ok ? 1 : 0, ok ? 0 : 1, ev);
    end

    ready = 1'b0;
    l0 = n_load; e0 = n_err;
    send_frame(24'h111111, FB, -1, 0, 1'b0, 1'b0, ok, ev);
    expect_frame("bp_first", l0, e0, 1, 0, 24'h111111);
    check("bp_ovr0", 32'(ovr), 32'h0);
    send_frame(24'h222222, FB, -1, 0, 1'b0, 1'b0, ok, ev);
    check("bp_hold", 32'(fdata), 32'h111111);
    check("bp_valid", 32'(fvalid), 32'h1);
    check("bp_ovr1", 32'(ovr), 32'h1);
    ready = 1'b1;
    @(negedge clk);
    check("bp_valid_pre", 32'(fvalid), 32'h1);
    @(posedge clk);
    #1;
    check("bp_valid_drop", 32'(fvalid), 32'h0);

    send_frame(24'h5A5A5A, 12, -1, 0, 1'b0, 1'b0, ok, ev);
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mrst_data", 32'(fdata), 32'h0);
    check("mrst_valid", 32'(fvalid), 32'h0);
    check("mrst_err", 32'(ferr), 32'h0);
    check("mrst_ovr", 32'(ovr), 32'h0);
    rst = 1'b0;
    d = FB'($urandom);
    l0 = n_load; e0 = n_err;
    send_frame(d, FB, -1, 0, 1'b0, 1'b0, ok, ev);
    expect_frame("post_rst", l0, e0, ok ? 1 : 0, ok ? 0 : 1, ev);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
